// File: rtl/data_bus_arbiter.sv
// Two-master data-bus arbiter with registered grant, slave wait states and a watchdog timeout.
// Define ARBITER_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (M0 wins) otherwise.
module data_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned WAIT_W         = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_read_enable,
  input  logic        m0_write_enable,
  output logic [31:0] m0_read_data,
  output logic        m0_ready,
  output logic        m0_error,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_read_enable,
  input  logic        m1_write_enable,
  output logic [31:0] m1_read_data,
  output logic        m1_ready,
  output logic        m1_error,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;   // 1 = M1 owned the bus last
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic req0, req1, sel, sel_req, oth_req, sel_re, sel_we;
  logic tie_m1, keep_owner, done, fault;

  assign req0    = m0_read_enable | m0_write_enable;
  assign req1    = m1_read_enable | m1_write_enable;
  assign sel     = (state_q == OWN_M1);
  assign sel_req = sel ? req1 : req0;
  assign oth_req = sel ? req0 : req1;
  assign sel_re  = sel ? m1_read_enable  : m0_read_enable;
  assign sel_we  = sel ? m1_write_enable : m0_write_enable;

  // tie_m1: who wins a tie in IDLE; keep_owner: owner may keep the bus on a tie at completion
`ifdef ARBITER_ROUND_ROBIN_EN
  assign tie_m1     = ~last_q;
  assign keep_owner = 1'b0;
`else
  logic unused_last_owner;
  assign tie_m1            = 1'b0;
  assign keep_owner        = ~sel;
  assign unused_last_owner = last_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    wait_d           = wait_q;
    done             = 1'b0;
    fault            = 1'b0;
    bus_address      = '0;
    bus_write_data   = '0;
    bus_byte_enable  = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    m0_read_data     = '0;
    m1_read_data     = '0;

    // Outputs are forced low while reset is asserted so an in-flight access never completes.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req0 && req1)
            state_d = tie_m1 ? OWN_M1 : OWN_M0;
          else if (req0)
            state_d = OWN_M0;
          else if (req1)
            state_d = OWN_M1;
        end
        OWN_M0, OWN_M1: begin
          bus_address      = sel ? m1_address     : m0_address;
          bus_write_data   = sel ? m1_write_data  : m0_write_data;
          bus_byte_enable  = sel ? m1_byte_enable : m0_byte_enable;
          bus_write_enable = sel_we;
          bus_read_enable  = sel_re & ~sel_we;
          if (sel)
            m1_read_data = bus_read_data;
          else
            m0_read_data = bus_read_data;

          if (bus_ready) begin
            done   = 1'b1;
            last_d = sel;
            wait_d = '0;
            if (!oth_req)
              state_d = IDLE;
            else if (sel_req && keep_owner)
              state_d = state_q;
            else
              state_d = sel ? OWN_M0 : OWN_M1;
          end else if (!sel_req) begin
            bus_read_enable  = 1'b0;
            bus_write_enable = 1'b0;
            state_d          = IDLE;
            wait_d           = '0;
          end else if (wait_q == WAIT_LAST) begin
            bus_read_enable  = 1'b0;
            bus_write_enable = 1'b0;
            done             = 1'b1;
            fault            = 1'b1;
            state_d          = IDLE;
            wait_d           = '0;
          end else if (wait_q != '1) begin
            wait_d = wait_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    m0_ready = done  & ~sel;
    m1_ready = done  &  sel;
    m0_error = fault & ~sel;
    m1_error = fault &  sel;
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with TIMEOUT_CYCLES=4; follows ARBITER_ROUND_ROBIN_EN if defined.
module tb_data_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m0_write_data, m0_read_data;
  logic [3:0]  m0_byte_enable;
  logic        m0_read_enable, m0_write_enable, m0_ready, m0_error;
  logic [31:0] m1_address, m1_write_data, m1_read_data;
  logic [3:0]  m1_byte_enable;
  logic        m1_read_enable, m1_write_enable, m1_ready, m1_error;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable, bus_ready;

  int checks = 0;
  int errors = 0;

  // Flag bits: {m1_error, m1_ready, m0_error, m0_ready, bus_write_enable, bus_read_enable}
  localparam logic [31:0] F_RE = 32'h01, F_WE = 32'h02, F_R0 = 32'h04;
  localparam logic [31:0] F_E0 = 32'h08, F_R1 = 32'h10, F_E1 = 32'h20;
  logic [5:0] fl;
  assign fl = {m1_error, m1_ready, m0_error, m0_ready, bus_write_enable, bus_read_enable};

  always #5 clock = ~clock;

  data_bus_arbiter #(.TIMEOUT_CYCLES(4), .WAIT_W(8)) dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_write_data(m0_write_data), .m0_byte_enable(m0_byte_enable),
    .m0_read_enable(m0_read_enable), .m0_write_enable(m0_write_enable),
    .m0_read_data(m0_read_data), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_address(m1_address), .m1_write_data(m1_write_data), .m1_byte_enable(m1_byte_enable),
    .m1_read_enable(m1_read_enable), .m1_write_enable(m1_write_enable),
    .m1_read_data(m1_read_data), .m1_ready(m1_ready), .m1_error(m1_error),
    .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_byte_enable(bus_byte_enable),
    .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
    .bus_read_data(bus_read_data), .bus_ready(bus_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m0_address = '0; m0_write_data = '0; m0_byte_enable = '0;
    m0_read_enable = 1'b0; m0_write_enable = 1'b0;
    m1_address = '0; m1_write_data = '0; m1_byte_enable = '0;
    m1_read_enable = 1'b0; m1_write_enable = 1'b0;
    bus_read_data = '0; bus_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [1:0] exp_grant [4];
`ifdef ARBITER_ROUND_ROBIN_EN
    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    // Reset state, with requests and a ready slave presented during reset
    reset = 1'b1;
    idle_inputs();
    m0_read_enable = 1'b1; bus_ready = 1'b1; bus_read_data = 32'hFFFF_FFFF;
    tick(); tick();
    #1;
    check("rst_flags", 32'(fl), '0);
    check("rst_addr", bus_address, '0);
    check("rst_m0_rdata", m0_read_data, '0);

    // M0 read with zero-wait slave
    do_reset();
    m0_address = 32'h100; m0_read_enable = 1'b1;
    #1 check("t1_c0_flags", 32'(fl), '0);
    tick();
    bus_ready = 1'b1; bus_read_data = 32'hDEAD_BEEF;
    #1;
    check("t1_c1_flags", 32'(fl), F_RE | F_R0);
    check("t1_c1_addr", bus_address, 32'h100);
    check("t1_c1_m0_rdata", m0_read_data, 32'hDEAD_BEEF);
    check("t1_c1_m1_rdata", m1_read_data, '0);
    m0_read_enable = 1'b0;
    tick();
    #1;
    check("t1_c2_flags", 32'(fl), '0);
    check("t1_c2_m0_rdata", m0_read_data, '0);

    // Simultaneous writes, back-to-back handoff
    do_reset();
    m0_address = 32'h10; m0_write_data = 32'hA0A0_A0A0; m0_byte_enable = 4'hF; m0_write_enable = 1'b1;
    m1_address = 32'h20; m1_write_data = 32'hB1B1_B1B1; m1_byte_enable = 4'h3; m1_write_enable = 1'b1;
    bus_ready = 1'b1;
    #1 check("t2_c0_flags", 32'(fl), '0);
    tick();
    #1;
    check("t2_c1_flags", 32'(fl), F_WE | F_R0);
    check("t2_c1_addr", bus_address, 32'h10);
    check("t2_c1_wdata", bus_write_data, 32'hA0A0_A0A0);
    check("t2_c1_be", 32'(bus_byte_enable), 32'hF);
    m0_write_enable = 1'b0;
    tick();
    #1;
    check("t2_c2_flags", 32'(fl), F_WE | F_R1);
    check("t2_c2_addr", bus_address, 32'h20);
    check("t2_c2_wdata", bus_write_data, 32'hB1B1_B1B1);
    check("t2_c2_be", 32'(bus_byte_enable), 32'h3);
    m1_write_enable = 1'b0;
    tick();
    #1 check("t2_c3_flags", 32'(fl), '0);

    // Both masters requesting continuously
    do_reset();
    m0_address = 32'h200; m0_read_enable = 1'b1;
    m1_address = 32'h300; m1_read_enable = 1'b1;
    bus_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("t3_grant%0d", i), 32'({m1_ready, m0_ready}), 32'(exp_grant[i]));
      tick();
    end
    m0_read_enable = 1'b0; m1_read_enable = 1'b0;

    // M1 read timeout after 4 wait cycles
    do_reset();
    m1_address = 32'h40; m1_read_enable = 1'b1;
    tick();
    for (int w = 1; w <= 4; w++) begin
      #1 check($sformatf("t4_w%0d", w), 32'(fl), (w < 4) ? F_RE : (F_R1 | F_E1));
      if (w == 4) m1_read_enable = 1'b0;
      tick();
    end
    #1 check("t4_idle", 32'(fl), '0);

    // Reset during a wait state, then M1 served normally
    do_reset();
    m0_address = 32'h80; m0_write_data = 32'h5555_AAAA; m0_byte_enable = 4'hF; m0_write_enable = 1'b1;
    tick();
    #1 check("t5_w1", 32'(fl), F_WE);
    tick();
    reset = 1'b1;
    #1 check("t5_rst", 32'(fl), '0);
    tick();
    reset = 1'b0;
    #1;
    check("t5_after_flags", 32'(fl), '0);
    check("t5_after_addr", bus_address, '0);
    m0_write_enable = 1'b0;
    tick();
    m1_address = 32'h44; m1_read_enable = 1'b1; bus_ready = 1'b1; bus_read_data = 32'h1234_5678;
    #1 check("t5_m1_c0", 32'(fl), '0);
    tick();
    #1;
    check("t5_m1_flags", 32'(fl), F_RE | F_R1);
    check("t5_m1_addr", bus_address, 32'h44);
    check("t5_m1_rdata", m1_read_data, 32'h1234_5678);
    m1_read_enable = 1'b0;
    tick();

    // Abort in wait state clears the wait counter
    do_reset();
    m0_address = 32'h90; m0_read_enable = 1'b1;
    tick(); tick(); tick();
    m0_read_enable = 1'b0;
    #1 check("t6_abort", 32'(fl), '0);
    tick();
    m0_read_enable = 1'b1;
    #1 check("t6_idle", 32'(fl), '0);
    tick();
    for (int w = 1; w <= 4; w++) begin
      #1 check($sformatf("t6_w%0d", w), 32'(fl), (w < 4) ? F_RE : (F_R0 | F_E0));
      if (w == 4) m0_read_enable = 1'b0;
      tick();
    end
    #1 check("t6_end", 32'(fl), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
